// File: rtl/sbox_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_arb
// Purpose  : Shares one combinational AES forward S-box between NREQ byte
//            requesters. Round-robin arbitration issues at most one lookup per
//            cycle into a single pipeline stage; each lane owns a one-entry
//            response holding register with its own valid/ready handshake.
// Ports    : clk, reset         - clock, asynchronous active-high reset
//            req_valid/ready    - per-lane request handshake (ready is the grant)
//            req_data           - per-lane lookup index, lane i at [8i+7:8i]
//            rsp_valid/ready    - per-lane response handshake
//            rsp_data           - per-lane S-box result, lane i at [8i+7:8i]
//            busy               - lookup in flight or any response held
//            lookup_count       - wrapping count of grants issued
// Revision : 1.0 - initial release
// ============================================================================
module sbox_share_arb #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [8*NREQ-1:0] rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic [CNTW-1:0]   lookup_count
);

  localparam int                 c_lane_w   = $clog2(NREQ);
  localparam logic [c_lane_w-1:0] c_last_rst = c_lane_w'(NREQ - 1);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (0 maps to 0), then the
  // affine transform expressed as XOR of byte rotations plus 0x63.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // State
  logic                      s1_valid_q, s1_valid_d;
  logic [7:0]                s1_data_q, s1_data_d;
  logic [c_lane_w-1:0]       s1_lane_q, s1_lane_d;
  logic [c_lane_w-1:0]       last_q, last_d;
  logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][7:0]      hold_q, hold_d;
  logic [CNTW-1:0]           lookup_count_q, lookup_count_d;

  // Combinational
  logic [NREQ-1:0][7:0]      w_req_bytes;
  logic [NREQ-1:0]           w_in_s1;
  logic [NREQ-1:0]           w_eligible;
  logic                      w_gnt_valid;
  logic [c_lane_w-1:0]       w_gnt_lane;
  logic [7:0]                w_sbox_out;

  assign w_req_bytes = req_data;
  assign w_sbox_out  = sbox_fwd(s1_data_q);

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign w_in_s1[i]    = s1_valid_q && (s1_lane_q == c_lane_w'(i));
      // A full holder only blocks its lane when it is not being popped now.
      assign w_eligible[i] = req_valid[i] && !w_in_s1[i] &&
                             (!rsp_valid_q[i] || rsp_ready[i]);
      assign req_ready[i]  = w_gnt_valid && (w_gnt_lane == c_lane_w'(i));
    end
  endgenerate

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_lane  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt_valid && w_eligible[c_lane_w'((int'(last_q) + k) % NREQ)]) begin
        w_gnt_valid = 1'b1;
        w_gnt_lane  = c_lane_w'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    s1_valid_d     = w_gnt_valid;
    s1_data_d      = s1_data_q;
    s1_lane_d      = s1_lane_q;
    last_d         = last_q;
    lookup_count_d = lookup_count_q;
    if (w_gnt_valid) begin
      s1_data_d      = w_req_bytes[w_gnt_lane];
      s1_lane_d      = w_gnt_lane;
      last_d         = w_gnt_lane;
      lookup_count_d = lookup_count_q + CNTW'(1);
    end
    // Refill wins over a simultaneous pop, so valid stays high.
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = w_in_s1[i] || (rsp_valid_q[i] && !rsp_ready[i]);
      hold_d[i]      = w_in_s1[i] ? w_sbox_out : hold_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_data_q      <= 8'h00;
      s1_lane_q      <= '0;
      last_q         <= c_last_rst;
      rsp_valid_q    <= '0;
      hold_q         <= '0;
      lookup_count_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s1_lane_q      <= s1_lane_d;
      last_q         <= last_d;
      rsp_valid_q    <= rsp_valid_d;
      hold_q         <= hold_d;
      lookup_count_q <= lookup_count_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = hold_q;
  assign busy         = s1_valid_q || (|rsp_valid_q);
  assign lookup_count = lookup_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_share_arb
// Purpose  : Self-checking bench for sbox_share_arb. Directed scenarios and a
//            randomized phase are compared cycle by cycle against a
//            transaction-level reference model (in-flight list with due
//            cycles, per-lane holders, S-box from brute-force GF inverse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_share_arb;

  localparam int NREQ = 4;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [8*NREQ-1:0] rsp_data;
  logic [NREQ-1:0]   rsp_ready;
  logic              busy;
  logic [CNTW-1:0]   lookup_count;

  always #5 clk = ~clk;

  sbox_share_arb #(.NREQ(NREQ), .CNTW(CNTW)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .lookup_count (lookup_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference S-box ----------------
  function automatic int gmul(input int a, input int b);
    int p  = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return p & 'hff;
  endfunction

  logic [7:0] sbox_tab [256];

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] cst = 8'h63;
      for (int y = 1; y < 256; y++)
        if (gmul(x, y) == 1) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_tab[x] = s;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int lane; logic [7:0] val; int due; } fl_t;
  fl_t        m_fl[$];
  bit         m_full [NREQ];
  logic [7:0] m_hold [NREQ];
  int         m_last;
  int         m_count;
  int         cyc;
  int         g_lane;

  // ---------------- requesters ----------------
  bit              pv [NREQ];
  logic [7:0]      pd [NREQ];
  logic [7:0]      lane_q [NREQ][$];
  bit              rnd_req = 1'b0;
  bit              rr_rnd  = 1'b0;
  logic [NREQ-1:0] rr_mask = '1;

  task automatic model_reset();
    m_fl.delete();
    for (int i = 0; i < NREQ; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = 8'h00;
      pv[i]     = 1'b0;
    end
    m_last  = NREQ - 1;
    m_count = 0;
  endtask

  function automatic bit in_flight(input int l);
    foreach (m_fl[j]) if (m_fl[j].lane == l) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!pv[i]) begin
        if (lane_q[i].size() > 0) begin
          pv[i] = 1'b1;
          pd[i] = lane_q[i].pop_front();
        end else if (rnd_req && $urandom_range(99) < 60) begin
          pv[i] = 1'b1;
          pd[i] = 8'($urandom);
        end
      end
      req_valid[i]       = pv[i];
      req_data[8*i +: 8] = pv[i] ? pd[i] : 8'($urandom);
    end
    rsp_ready = rr_rnd ? NREQ'($urandom) : rr_mask;
  endtask

  task automatic eval_check();
    logic [NREQ-1:0]   exp_ready = '0;
    logic [NREQ-1:0]   exp_rv    = '0;
    logic [8*NREQ-1:0] exp_rd;
    bit                exp_busy;
    g_lane = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int l = (m_last + k) % NREQ;
      if (g_lane < 0 && pv[l] && !in_flight(l) && (!m_full[l] || rsp_ready[l]))
        g_lane = l;
    end
    if (g_lane >= 0) exp_ready[g_lane] = 1'b1;
    exp_busy = (m_fl.size() > 0);
    for (int i = 0; i < NREQ; i++) begin
      exp_rv[i]        = m_full[i];
      exp_rd[8*i +: 8] = m_hold[i];
      if (m_full[i]) exp_busy = 1'b1;
    end
    chk($sformatf("req_ready@%0d", cyc), 32'(req_ready), 32'(exp_ready));
    chk($sformatf("rsp_valid@%0d", cyc), 32'(rsp_valid), 32'(exp_rv));
    chk($sformatf("rsp_data@%0d", cyc), rsp_data, exp_rd);
    chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(exp_busy));
    chk($sformatf("lookup_count@%0d", cyc), 32'(lookup_count), 32'(m_count % (1 << CNTW)));
  endtask

  task automatic advance();
    for (int i = 0; i < NREQ; i++)
      if (m_full[i] && rsp_ready[i]) m_full[i] = 1'b0;
    for (int j = m_fl.size() - 1; j >= 0; j--) begin
      if (m_fl[j].due == cyc + 1) begin
        m_full[m_fl[j].lane] = 1'b1;
        m_hold[m_fl[j].lane] = m_fl[j].val;
        m_fl.delete(j);
      end
    end
    if (g_lane >= 0) begin
      m_fl.push_back('{g_lane, sbox_tab[pd[g_lane]], cyc + 2});
      m_count++;
      m_last     = g_lane;
      pv[g_lane] = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      drive_inputs();
      @(negedge clk);
      eval_check();
      @(posedge clk);
      advance();
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
    cyc       = 0;
    build_sbox();
    model_reset();
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_count", 32'(lookup_count), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single lookup on lane 0
    lane_q[0].push_back(8'h00);
    run(2);
    chk("single_rsp_valid", 32'(rsp_valid[0]), 32'h1);
    chk("single_rsp_data", 32'(rsp_data[7:0]), 32'h63);
    chk("single_count", 32'(lookup_count), 32'h1);
    run(4);

    // All four lanes contend
    lane_q[0].push_back(8'h00);
    lane_q[1].push_back(8'h01);
    lane_q[2].push_back(8'h10);
    lane_q[3].push_back(8'h53);
    run(8);

    // Fairness between lanes 0 and 3
    for (int k = 0; k < 8; k++) begin
      lane_q[0].push_back(8'($urandom));
      lane_q[3].push_back(8'($urandom));
    end
    run(22);

    // Back-pressure on lane 1 while lane 2 keeps streaming
    rr_mask = 4'b1101;
    lane_q[1].push_back(8'hFF);
    lane_q[1].push_back(8'h00);
    for (int k = 0; k < 10; k++) lane_q[2].push_back(8'($urandom));
    run(8);
    chk("bp_rsp_valid", 32'(rsp_valid[1]), 32'h1);
    chk("bp_rsp_data", 32'(rsp_data[15:8]), 32'h16);
    rr_mask = 4'b1111;
    run(14);

    // Pop and refill in the same cycle
    lane_q[0].push_back(8'h00);
    lane_q[0].push_back(8'h53);
    run(8);

    // Reset with stage 1 and two holders occupied
    rr_mask = 4'b0000;
    lane_q[0].push_back(8'h11);
    lane_q[1].push_back(8'h22);
    lane_q[2].push_back(8'h33);
    run(3);
    drive_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    reset   = 1'b0;
    rr_mask = 4'b1111;
    lane_q[0].push_back(8'h01);
    lane_q[2].push_back(8'h02);
    run(1);
    chk("postrst_count", 32'(lookup_count), 32'h1);
    run(5);

    // Randomized traffic and back-pressure
    rnd_req = 1'b1;
    rr_rnd  = 1'b1;
    run(1500);
    rnd_req = 1'b0;
    rr_rnd  = 1'b0;
    rr_mask = 4'b1111;
    run(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sbox_share_arb.md
# sbox_share_arb

Time-multiplexes one combinational AES forward S-box between `NREQ` byte requesters, such as key-expansion and SubBytes lanes. Each requester gets a valid/ready request port and a one-entry response holding register with its own valid/ready handshake. Arbitration is round-robin, with at most one lookup issued per cycle. The block sits between the round/key-schedule sequencers and the single S-box instance.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `CNTW`, default 16: width of the lookup statistics counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: request present, one bit per lane.
- `req_data` input 8*NREQ: lookup index; lane i occupies bits [8i+7:8i].
- `req_ready` output NREQ: lane i is granted this cycle; combinational, one-hot or zero.
- `rsp_valid` output NREQ: lane i holding register is full.
- `rsp_data` output 8*NREQ: S-box result for lane i; lane i occupies bits [8i+7:8i].
- `rsp_ready` input NREQ: lane i consumes its response this cycle.
- `busy` output 1: a lookup is in stage 1, or any `rsp_valid` is set.
- `lookup_count` output CNTW: number of grants issued, wrapping.

## Operation
- **Eligibility.** Lane i is eligible when all three hold:
  - `req_valid[i]` is high;
  - lane i is not in stage 1;
  - `rsp_valid[i]` is low, or `rsp_ready[i]` is high in the same cycle.
- **Arbitration.**
  - Round-robin pointer `last` holds the most recently granted lane. Search starts at `last+1` modulo NREQ; the first eligible lane is granted.
  - `req_ready[i]` is high only for the granted lane.
  - `last` updates only on a grant.
- **Stage 1.** On a grant, the byte and a lane tag are registered into stage 1 (`s1_valid`, `s1_data`, `s1_lane`). `s1_valid` clears when no grant occurs.
- **S-box.** Driven combinationally from `s1_data`.
- **Hold capture.** When `s1_valid` is set, the S-box output is written into the hold register of lane `s1_lane`, and that lane's `rsp_valid` is set.
- **Hold release.** `rsp_valid[i]` clears on `rsp_valid[i]` and `rsp_ready[i]`, unless it is refilled in the same cycle. A refill takes priority and leaves `rsp_valid[i]` high.
- **Contract.** A requester must not make `req_valid` depend on `req_ready`. `req_data` must be stable while `req_valid` is high and ungranted.
- **Statistics.** `lookup_count` increments by 1 per grant and wraps modulo 2^CNTW.
- **Reset values.** Reset (asynchronous, any time) forces:
  - `s1_valid`, all `rsp_valid`, `lookup_count` to 0;
  - `last` to NREQ-1, so lane 0 has first priority;
  - hold data to 0x00.
  
  In-flight lookups are discarded, with no response.

## Timing
- **Latency.** A grant in cycle N puts the result on `rsp_valid`/`rsp_data` in cycle N+2.
- **Aggregate throughput.** One lookup per cycle when two or more lanes are eligible.
- **Per-lane throughput.** At most one grant per 2 cycles, because a lane in stage 1 is ineligible. This rate is sustained only if its response is popped in the cycle it appears.
- **Simultaneous pop and grant.** If lane i pops in cycle N and is granted in N, its new result appears at N+2. There is no bubble and no overwrite.
- **Back-pressure.** An unpopped full hold register blocks that lane only; the other lanes continue to be served.
- **Reset release.** The first grant is possible in the first clock edge after `reset` deasserts.

## Test plan
- **Single lookup.** Lane 0 requests 0x00; everything else idle.
  - `req_ready[0]` is high in cycle N.
  - `rsp_valid[0]` is high with `rsp_data` 0x63 in N+2.
  - `lookup_count` reads 1.
- **All lanes contend.** All four lanes are valid in the same cycle with 0x00/0x01/0x10/0x53, and `rsp_ready` is tied high.
  - Grants go to lanes 0,1,2,3 in consecutive cycles.
  - Results are 0x63/0x7C/0xCA/0xED, each 2 cycles after its grant.
- **Round-robin fairness.** Lanes 0 and 3 request continuously with `rsp_ready` high.
  - Grants alternate 0,3,0,3.
  - Neither lane is granted twice in a row.
- **Back-pressure.** Lane 1 requests 0xFF with `rsp_ready[1]` low.
  - Hold shows 0x16 and `rsp_valid[1]` stays high.
  - Lane 1 gets no further grants while lane 2 continues to be granted.
  - Raising `rsp_ready[1]` allows a lane 1 grant in the same cycle.
- **Pop/refill same cycle.** Lane 0 pops 0x63 while granted a new request for 0x53.
  - `rsp_valid[0]` falls for exactly one cycle.
  - 0xED appears 2 cycles after the grant.
- **Reset mid-operation.** Assert `reset` with stage 1 and two hold registers occupied.
  - `rsp_valid` and `busy` go to 0 immediately, without waiting for a clock edge.
  - The in-flight response is never delivered.
  - After release, lane 0 wins arbitration over lane 2, and `lookup_count` restarts from 0.
